// File: rtl/safety_clic_irq_bridge.sv
// Bridges the safety-island CLIC valid/ready interrupt offer onto one level-sensitive
// cv32e40p irq_i line, and turns the core's irq_ack into the CLIC claim handshake.
module safety_clic_irq_bridge #(
    parameter int NumInterrupts = 256,
    parameter int IdWidth       = $clog2(NumInterrupts),
    parameter int LevelWidth    = 8,
    parameter int CoreIrqLine   = 11,
    parameter int CntWidth      = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clic_irq_valid_i,
    output logic                  clic_irq_ready_o,
    input  logic [IdWidth-1:0]    clic_irq_id_i,
    input  logic [LevelWidth-1:0] clic_irq_level_i,
    input  logic                  clic_irq_shv_i,
    input  logic [LevelWidth-1:0] thresh_i,
    output logic [31:0]           core_irq_o,
    input  logic                  core_irq_ack_i,
    input  logic [4:0]            core_irq_id_i,
    output logic [IdWidth-1:0]    last_id_o,
    output logic [LevelWidth-1:0] last_level_o,
    output logic                  last_shv_o,
    output logic [CntWidth-1:0]   taken_cnt_o,
    output logic                  spurious_o,
    input  logic                  spurious_clr_i,
    output logic [1:0]            dbg_state_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PEND = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    localparam logic [4:0]          LINE_ID = 5'(CoreIrqLine);
    localparam logic [CntWidth-1:0] CNT_MAX = {CntWidth{1'b1}};

    logic [1:0]            r_state;
    logic                  r_irq;
    logic                  r_ready;
    logic [IdWidth-1:0]    r_cap_id;
    logic [LevelWidth-1:0] r_cap_level;
    logic                  r_cap_shv;
    logic [IdWidth-1:0]    r_last_id;
    logic [LevelWidth-1:0] r_last_level;
    logic                  r_last_shv;
    logic [CntWidth-1:0]   r_taken_cnt;
    logic                  r_spurious;

    logic                  w_fwd;
    logic                  w_ack_ours;
    logic                  w_changed;
    logic                  w_spur_set;
    logic [31:0]           w_irq_vec;

    // Threshold masking is strict: a level equal to the threshold is not forwarded.
    assign w_fwd      = clic_irq_valid_i && (clic_irq_level_i > thresh_i);
    assign w_ack_ours = core_irq_ack_i && (core_irq_id_i == LINE_ID);
    assign w_changed  = (clic_irq_id_i != r_cap_id) || (clic_irq_level_i != r_cap_level)
                        || (clic_irq_shv_i != r_cap_shv);
    assign w_spur_set = (r_state == ST_ACK) && !clic_irq_valid_i;

    always_comb begin
        w_irq_vec              = '0;
        w_irq_vec[CoreIrqLine] = r_irq;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_irq        <= 1'b0;
            r_ready      <= 1'b0;
            r_cap_id     <= '0;
            r_cap_level  <= '0;
            r_cap_shv    <= 1'b0;
            r_last_id    <= '0;
            r_last_level <= '0;
            r_last_shv   <= 1'b0;
            r_taken_cnt  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_fwd) begin
                        r_cap_id    <= clic_irq_id_i;
                        r_cap_level <= clic_irq_level_i;
                        r_cap_shv   <= clic_irq_shv_i;
                        r_irq       <= 1'b1;
                        r_state     <= ST_PEND;
                    end
                end
                ST_PEND: begin
                    // The core has already trapped on an ack, so it beats a same-cycle withdrawal.
                    if (w_ack_ours) begin
                        r_last_id    <= r_cap_id;
                        r_last_level <= r_cap_level;
                        r_last_shv   <= r_cap_shv;
                        r_irq        <= 1'b0;
                        r_ready      <= 1'b1;
                        r_state      <= ST_ACK;
                    end else if (!w_fwd) begin
                        r_irq   <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (w_changed) begin
                        r_cap_id    <= clic_irq_id_i;
                        r_cap_level <= clic_irq_level_i;
                        r_cap_shv   <= clic_irq_shv_i;
                    end
                end
                ST_ACK: begin
                    if (clic_irq_valid_i && r_taken_cnt != CNT_MAX) begin
                        r_taken_cnt <= r_taken_cnt + CntWidth'(1);
                    end
                    r_ready <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_irq   <= 1'b0;
                    r_ready <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_spurious <= 1'b0;
        end else if (w_spur_set) begin
            r_spurious <= 1'b1;
        end else if (spurious_clr_i) begin
            r_spurious <= 1'b0;
        end
    end

    assign clic_irq_ready_o = r_ready;
    assign core_irq_o       = w_irq_vec;
    assign last_id_o        = r_last_id;
    assign last_level_o     = r_last_level;
    assign last_shv_o       = r_last_shv;
    assign taken_cnt_o      = r_taken_cnt;
    assign spurious_o       = r_spurious;
    assign dbg_state_o      = r_state;

endmodule

// File: tb/tb_safety_clic_irq_bridge.sv
// Directed bench for safety_clic_irq_bridge; a second instance with a 2-bit counter
// shares all inputs so counter saturation is reached in a handful of claims.
module tb_safety_clic_irq_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [7:0]  id = '0;
    logic [7:0]  level = '0;
    logic        shv = 1'b0;
    logic [7:0]  thresh = '0;
    logic        ack = 1'b0;
    logic [4:0]  ack_id = '0;
    logic        spur_clr = 1'b0;

    logic        ready, ready_s;
    logic [31:0] core_irq, core_irq_s;
    logic [7:0]  last_id, last_id_s;
    logic [7:0]  last_level, last_level_s;
    logic        last_shv, last_shv_s;
    logic [15:0] cnt;
    logic [1:0]  cnt_s;
    logic        spurious, spurious_s;
    logic [1:0]  state, state_s;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;

    always #5 clk = ~clk;

    safety_clic_irq_bridge dut (
        .clk_i(clk), .rst_i(rst), .clic_irq_valid_i(valid), .clic_irq_ready_o(ready),
        .clic_irq_id_i(id), .clic_irq_level_i(level), .clic_irq_shv_i(shv), .thresh_i(thresh),
        .core_irq_o(core_irq), .core_irq_ack_i(ack), .core_irq_id_i(ack_id),
        .last_id_o(last_id), .last_level_o(last_level), .last_shv_o(last_shv),
        .taken_cnt_o(cnt), .spurious_o(spurious), .spurious_clr_i(spur_clr), .dbg_state_o(state)
    );

    safety_clic_irq_bridge #(.CntWidth(2)) dut_small (
        .clk_i(clk), .rst_i(rst), .clic_irq_valid_i(valid), .clic_irq_ready_o(ready_s),
        .clic_irq_id_i(id), .clic_irq_level_i(level), .clic_irq_shv_i(shv), .thresh_i(thresh),
        .core_irq_o(core_irq_s), .core_irq_ack_i(ack), .core_irq_id_i(ack_id),
        .last_id_o(last_id_s), .last_level_o(last_level_s), .last_shv_o(last_shv_s),
        .taken_cnt_o(cnt_s), .spurious_o(spurious_s), .spurious_clr_i(spur_clr), .dbg_state_o(state_s)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [7:0] i_id, input logic [7:0] i_lvl, input logic i_shv);
        valid = 1'b1;
        id    = i_id;
        level = i_lvl;
        shv   = i_shv;
    endtask

    // Full offer/ack/claim sequence; leaves valid low and the bridge idle.
    task automatic claim(input logic [7:0] i_id, input logic [7:0] i_lvl);
        offer(i_id, i_lvl, 1'b0);
        tick();
        ack = 1'b1; ack_id = 5'd11;
        tick();
        ack = 1'b0;
        tick();
        valid = 1'b0;
        exp_cnt++;
    endtask

    initial begin
        tick();
        tick();
        check("rst_irq", core_irq, 32'h0);
        check("rst_ready", {31'b0, ready}, 32'h0);
        check("rst_cnt", {16'b0, cnt}, 32'h0);
        check("rst_state", {30'b0, state}, 32'h0);
        rst = 1'b0;
        tick();

        // Basic forward/ack/claim with exact cycle latencies.
        thresh = 8'd3;
        offer(8'd5, 8'd8, 1'b0);
        tick();
        check("t1_line_n1", core_irq, 32'h800);
        check("t1_ready_n1", {31'b0, ready}, 32'h0);
        tick();
        ack = 1'b1; ack_id = 5'd11;
        tick();
        ack = 1'b0;
        check("t1_ready_n4", {31'b0, ready}, 32'h1);
        check("t1_line_n4", core_irq, 32'h0);
        check("t1_last_id", {24'b0, last_id}, 32'd5);
        check("t1_last_lvl", {24'b0, last_level}, 32'd8);
        tick();
        valid = 1'b0;
        exp_cnt++;
        check("t1_ready_n5", {31'b0, ready}, 32'h0);
        check("t1_cnt", {16'b0, cnt}, 32'd1);
        tick();

        // Threshold boundary: equal level is masked, one above forwards next cycle.
        thresh = 8'd2;
        offer(8'd4, 8'd2, 1'b0);
        tick();
        tick();
        check("t2_eq_line", core_irq, 32'h0);
        check("t2_eq_ready", {31'b0, ready}, 32'h0);
        level = 8'd3;
        tick();
        check("t2_gt_line", core_irq, 32'h800);
        thresh = 8'd3;
        tick();
        check("t2_thr_mask", core_irq, 32'h0);
        valid = 1'b0;
        tick();

        // Preemption while pending.
        thresh = 8'd3;
        offer(8'd5, 8'd8, 1'b0);
        tick();
        offer(8'd9, 8'd12, 1'b1);
        tick();
        check("t3_line_hold", core_irq, 32'h800);
        ack = 1'b1; ack_id = 5'd11;
        tick();
        ack = 1'b0;
        check("t3_last_id", {24'b0, last_id}, 32'd9);
        check("t3_last_lvl", {24'b0, last_level}, 32'd12);
        check("t3_last_shv", {31'b0, last_shv}, 32'h1);
        tick();
        valid = 1'b0;
        exp_cnt++;
        check("t3_cnt", {16'b0, cnt}, exp_cnt);

        // Withdrawal racing an ack: ack wins, claim then finds no valid.
        offer(8'd7, 8'd4, 1'b0);
        tick();
        valid = 1'b0;
        ack = 1'b1; ack_id = 5'd11;
        tick();
        ack = 1'b0;
        check("t4_ready", {31'b0, ready}, 32'h1);
        tick();
        check("t4_spur", {31'b0, spurious}, 32'h1);
        check("t4_cnt", {16'b0, cnt}, exp_cnt);
        check("t4_ready_off", {31'b0, ready}, 32'h0);
        spur_clr = 1'b1;
        tick();
        check("t4_spur_clr", {31'b0, spurious}, 32'h0);
        // Set beats clear in the same cycle.
        offer(8'd7, 8'd4, 1'b0);
        tick();
        valid = 1'b0;
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        check("t4_set_prio", {31'b0, spurious}, 32'h1);
        spur_clr = 1'b0;
        tick();
        check("t4_spur_hold", {31'b0, spurious}, 32'h1);
        spur_clr = 1'b1;
        tick();
        spur_clr = 1'b0;

        // Wrong ack id ignored; plain withdrawal; ack in idle ignored.
        offer(8'd6, 8'd9, 1'b0);
        tick();
        ack = 1'b1; ack_id = 5'd3;
        tick();
        ack = 1'b0;
        check("t5_wrongid_line", core_irq, 32'h800);
        check("t5_wrongid_rdy", {31'b0, ready}, 32'h0);
        valid = 1'b0;
        tick();
        check("t5_withdraw", core_irq, 32'h0);
        ack = 1'b1; ack_id = 5'd11;
        tick();
        ack = 1'b0;
        check("t5_idle_ack", {31'b0, ready}, 32'h0);
        tick();

        // Saturation on the 2-bit instance, then async reset in PEND and ACK.
        for (int k = 0; k < 3; k++) claim(8'(k + 1), 8'd20);
        tick();
        check("t6_cnt_wide", {16'b0, cnt}, exp_cnt);
        check("t6_cnt_sat", {30'b0, cnt_s}, 32'h3);
        check("t6_last_id", {24'b0, last_id}, 32'd3);
        offer(8'd10, 8'd30, 1'b1);
        tick();
        rst = 1'b1;
        #1;
        check("t6_rst_pend_line", core_irq, 32'h0);
        check("t6_rst_pend_cnt", {16'b0, cnt}, 32'h0);
        check("t6_rst_pend_last", {15'b0, last_shv, last_level, last_id}, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        ack = 1'b1; ack_id = 5'd11;
        tick();
        ack = 1'b0;
        check("t6_in_ack", {31'b0, ready}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_rst_ack_ready", {31'b0, ready}, 32'h0);
        check("t6_rst_ack_cnt", {30'b0, cnt_s}, 32'h0);
        check("t6_rst_ack_state", {30'b0, state}, 32'h0);
        valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
